fetch_unit: RTL

Instruction fetch stage directly downstream of the PC register. Takes the current program counter, issues word requests to instruction memory over a request/grant port with variable read latency, and buffers returned instructions with their PC in a small FIFO. Entries go to decode over a valid/ready handshake. It pulses `pc_adv_o` on every accepted request so the next-PC logic loads PC+4, and supports a single-cycle flush for branch/jump redirects.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Entry layout and FSM states used by fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a clear input.
// Clear wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i &
                   ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, tag queue,
// instruction buffer and flush/drain handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_adv_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_fault_o,
  input  logic            if_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          stall_q, stall_d;
  logic          en_q, en_d;

  logic [CW-1:0] buf_cnt, tag_cnt;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t  buf_wdata, buf_rdata;
  logic          credit, aligned, can_go;
  logic          gnt_acc, fault_push;
  logic          rsp_any, rsp_take;
  logic          buf_push, buf_pop;

  assign credit  = ({1'b0, outst_q} + {1'b0, buf_cnt})
                   < (CW+1)'(DEPTH);
  assign aligned = pc_i[1:0] == 2'b00;
  assign can_go  = en_q & credit & !flush_i
                   & !stall_q & (state_q == RUN);

  assign imem_req_o  = can_go & aligned;
  assign imem_addr_o = pc_i;
  assign gnt_acc     = imem_req_o & imem_gnt_i;

  // Faults wait for older responses so order is kept
  assign fault_push = can_go & !aligned
                      & (outst_q == '0) & !imem_rvalid_i;
  assign pc_adv_o   = gnt_acc | fault_push;

  assign rsp_any  = imem_rvalid_i & (outst_q != '0);
  assign rsp_take = rsp_any & (state_q == RUN)
                    & !flush_i & (tag_cnt != '0);

  always_comb begin
    buf_wdata.pc    = tag_pc;
    buf_wdata.instr = imem_rdata_i;
    buf_wdata.fault = 1'b0;
    if (fault_push) begin
      buf_wdata.pc    = pc_i;
      buf_wdata.instr = '0;
      buf_wdata.fault = 1'b1;
    end
  end

  assign buf_push = rsp_take | fault_push;
  assign buf_pop  = if_valid_o & if_ready_i & !flush_i;
  assign en_d     = 1'b1;

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    stall_d = stall_q;
    outst_d = outst_q + CW'(gnt_acc) - CW'(rsp_any);
    if (fault_push) stall_d = 1'b1;
    if (flush_i) begin
      stall_d = 1'b0;
      disc_d  = outst_d;
      state_d = (outst_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && rsp_any) begin
      disc_d = disc_q - 1'b1;
      if (disc_q == CW'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      outst_q <= '0;
      disc_q  <= '0;
      stall_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      stall_q <= stall_d;
      en_q    <= en_d;
    end
  end

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_rdata),
    .count_o (buf_cnt)
  );

  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_tag (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (gnt_acc),
    .wdata_i (pc_i),
    .pop_i   (rsp_take),
    .rdata_o (tag_pc),
    .count_o (tag_cnt)
  );

  assign if_valid_o = buf_cnt != '0;
  assign if_instr_o = buf_rdata.instr;
  assign if_pc_o    = buf_rdata.pc;
  assign if_fault_o = buf_rdata.fault;

endmodule
